pulse_interval_analyzer: RTL and testbench

PULSE_INTERVAL_ANALYZER -- requirements
Module: pulse_interval_analyzer

---
 rtl/pulse_interval_analyzer.sv | 164 ++++++++++++++++
 tb/tb_pulse_interval_analyzer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_interval_analyzer.sv
// Measures high width and preceding low gap of an asynchronous pulse stream,
// presenting one record at a time through a valid/ready slot plus running statistics.
module pulse_interval_analyzer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          pulse_in,
  input  logic          clr_stats,
  input  logic          meas_ready,
  output logic          meas_valid,
  output logic [CW-1:0] meas_width,
  output logic [CW-1:0] meas_gap,
  output logic          meas_sat,
  output logic [CW-1:0] pulse_count,
  output logic [CW-1:0] min_width,
  output logic [CW-1:0] max_width,
  output logic          overrun
);

  localparam logic [1:0] ST_WAIT_LOW = 2'd0;
  localparam logic [1:0] ST_GAP      = 2'd1;
  localparam logic [1:0] ST_HIGH     = 2'd2;

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   w_s, w_rise, w_fall;

  logic [1:0]    r_state;
  logic [CW-1:0] r_gcnt, r_wcnt, r_glat;

  logic          r_c1_vld, r_c1_sat, r_c2_vld, r_c2_sat;
  logic [CW-1:0] r_c1_w, r_c1_g, r_c2_w, r_c2_g;

  logic          r_valid, r_sat, r_overrun;
  logic [CW-1:0] r_width, r_gap, r_count, r_min, r_max;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pulse_in};
      r_s_d  <= w_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_WAIT_LOW;
      r_gcnt   <= '0;
      r_wcnt   <= '0;
      r_glat   <= '0;
      r_c1_vld <= 1'b0;
      r_c1_w   <= '0;
      r_c1_g   <= '0;
      r_c1_sat <= 1'b0;
    end else begin
      r_c1_vld <= 1'b0;
      if (!ena) begin
        r_state <= ST_WAIT_LOW;
        r_gcnt  <= '0;
        r_wcnt  <= '0;
        r_glat  <= '0;
      end else begin
        case (r_state)
          // Only start once the line is seen low, so a pulse already high is never reported.
          ST_WAIT_LOW: if (!w_s) begin
            r_state <= ST_GAP;
            r_gcnt  <= ONE;
          end
          ST_GAP: if (w_rise) begin
            r_state <= ST_HIGH;
            r_glat  <= r_gcnt;
            r_wcnt  <= ONE;
          end else if (!w_s && r_gcnt != CMAX) begin
            r_gcnt <= r_gcnt + ONE;
          end
          ST_HIGH: if (w_fall) begin
            r_state  <= ST_GAP;
            r_gcnt   <= ONE;
            r_c1_vld <= 1'b1;
            r_c1_w   <= r_wcnt;
            r_c1_g   <= r_glat;
            r_c1_sat <= (r_wcnt == CMAX) || (r_glat == CMAX);
          end else if (w_s && r_wcnt != CMAX) begin
            r_wcnt <= r_wcnt + ONE;
          end
          default: r_state <= ST_WAIT_LOW;
        endcase
      end
    end
  end

  // Extra stage so a record lands SYNC_STAGES+2 cycles after the sampled fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c2_vld <= 1'b0;
      r_c2_w   <= '0;
      r_c2_g   <= '0;
      r_c2_sat <= 1'b0;
    end else begin
      r_c2_vld <= r_c1_vld;
      r_c2_w   <= r_c1_w;
      r_c2_g   <= r_c1_g;
      r_c2_sat <= r_c1_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_width <= '0;
      r_gap   <= '0;
      r_sat   <= 1'b0;
    end else if (r_c2_vld && (!r_valid || meas_ready)) begin
      r_valid <= 1'b1;
      r_width <= r_c2_w;
      r_gap   <= r_c2_g;
      r_sat   <= r_c2_sat;
    end else if (r_valid && meas_ready) begin
      r_valid <= 1'b0;
    end
  end

  // A clear coincident with a completion restarts the statistics from that pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= '0;
      r_min     <= '1;
      r_max     <= '0;
      r_overrun <= 1'b0;
    end else if (clr_stats) begin
      r_count   <= r_c2_vld ? ONE : '0;
      r_min     <= r_c2_vld ? r_c2_w : '1;
      r_max     <= r_c2_vld ? r_c2_w : '0;
      r_overrun <= 1'b0;
    end else if (r_c2_vld) begin
      r_count <= r_count + ONE;
      if (r_c2_w < r_min) r_min <= r_c2_w;
      if (r_c2_w > r_max) r_max <= r_c2_w;
      if (r_valid && !meas_ready) r_overrun <= 1'b1;
    end
  end

  assign meas_valid  = r_valid;
  assign meas_width  = r_width;
  assign meas_gap    = r_gap;
  assign meas_sat    = r_sat;
  assign pulse_count = r_count;
  assign min_width   = r_min;
  assign max_width   = r_max;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_pulse_interval_analyzer.sv
// Scoreboard bench: expected records are queued at stimulus time and checked on each accepted handshake.
module tb_pulse_interval_analyzer;

  localparam int unsigned SS = 2;
  localparam int unsigned CW = 16;

  typedef struct {
    logic [CW-1:0] w;
    logic [CW-1:0] g;
    logic          sat;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst, ena, pulse_in, clr_stats, meas_ready;
  logic          meas_valid, meas_sat, overrun;
  logic [CW-1:0] meas_width, meas_gap, pulse_count, min_width, max_width;

  int   checks = 0;
  int   errors = 0;
  rec_t sb[$];
  rec_t mon_e;
  logic [82:0] got_all, exp_all;

  pulse_interval_analyzer #(.SYNC_STAGES(SS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in), .clr_stats(clr_stats),
    .meas_ready(meas_ready), .meas_valid(meas_valid), .meas_width(meas_width),
    .meas_gap(meas_gap), .meas_sat(meas_sat), .pulse_count(pulse_count),
    .min_width(min_width), .max_width(max_width), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Handshake monitor: a record is accepted at the posedge following this negedge.
  always @(negedge clk) begin
    if (!rst && meas_valid && meas_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL record_unexpected: got w=%0d g=%0d s=%b expected no record", meas_width, meas_gap, meas_sat);
      end else begin
        mon_e = sb.pop_front();
        if ({meas_width, meas_gap, meas_sat} !== {mon_e.w, mon_e.g, mon_e.sat}) begin
          errors++;
          $display("FAIL record: got w=%0d g=%0d s=%b expected w=%0d g=%0d s=%b",
                   meas_width, meas_gap, meas_sat, mon_e.w, mon_e.g, mon_e.sat);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int gap, input int width);
    pulse_in = 1'b0;
    cyc(gap);
    pulse_in = 1'b1;
    cyc(width);
  endtask

  // Reset with the line held high, then enable while still high so no partial pulse is measured.
  task automatic restart();
    meas_ready = 1'b0; ena = 1'b0; pulse_in = 1'b1; clr_stats = 1'b0; rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(SS + 2);
    ena = 1'b1;
    cyc(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; pulse_in = 1'b0; clr_stats = 1'b0; meas_ready = 1'b0;
    cyc(3);
    got_all = {meas_valid, meas_width, meas_gap, meas_sat, pulse_count, min_width, max_width, overrun};
    exp_all = {1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 1'b0};
    checks++;
    if (got_all !== exp_all) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", got_all, exp_all);
    end
  endtask

  task automatic test_basic();
    restart();
    meas_ready = 1'b1;
    sb.push_back('{16'd5, 16'd10, 1'b0});
    pulse(10, 5);
    pulse_in = 1'b0;
    cyc(SS + 2);
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", meas_valid); end
    cyc(1);
    checks++;
    if ({meas_valid, meas_width, meas_gap, meas_sat} !== {1'b1, 16'd5, 16'd10, 1'b0}) begin
      errors++;
      $display("FAIL basic_record: got v=%b w=%0d g=%0d s=%b expected v=1 w=5 g=10 s=0", meas_valid, meas_width, meas_gap, meas_sat);
    end
    checks++;
    if ({pulse_count, min_width, max_width} !== {16'd1, 16'd5, 16'd5}) begin
      errors++;
      $display("FAIL basic_stats: got cnt=%0d min=%0d max=%0d expected cnt=1 min=5 max=5", pulse_count, min_width, max_width);
    end
    cyc(1);
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", meas_valid); end
  endtask

  task automatic test_overrun();
    restart();
    sb.push_back('{16'd3, 16'd4, 1'b0});
    pulse(4, 3);
    pulse(4, 7);
    pulse(4, 2);
    pulse_in = 1'b0;
    cyc(SS + 4);
    checks++;
    if ({meas_valid, meas_width, meas_gap, overrun} !== {1'b1, 16'd3, 16'd4, 1'b1}) begin
      errors++;
      $display("FAIL overrun_hold: got v=%b w=%0d g=%0d ovr=%b expected v=1 w=3 g=4 ovr=1", meas_valid, meas_width, meas_gap, overrun);
    end
    checks++;
    if ({pulse_count, min_width, max_width} !== {16'd3, 16'd2, 16'd7}) begin
      errors++;
      $display("FAIL overrun_stats: got cnt=%0d min=%0d max=%0d expected cnt=3 min=2 max=7", pulse_count, min_width, max_width);
    end
    meas_ready = 1'b1;
    cyc(1);
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain: got %b expected 0", meas_valid); end
  endtask

  task automatic test_back_to_back();
    restart();
    sb.push_back('{16'd3, 16'd4, 1'b0});
    sb.push_back('{16'd5, 16'd4, 1'b0});
    pulse(4, 3);
    pulse(4, 5);
    pulse_in = 1'b0;
    cyc(SS + 2);
    meas_ready = 1'b1;
    cyc(1);
    checks++;
    if ({meas_valid, meas_width, overrun} !== {1'b1, 16'd5, 1'b0}) begin
      errors++;
      $display("FAIL b2b_reload: got v=%b w=%0d ovr=%b expected v=1 w=5 ovr=0", meas_valid, meas_width, overrun);
    end
    cyc(1);
    checks++;
    if (meas_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", meas_valid); end
  endtask

  task automatic test_clr_coincident();
    restart();
    sb.push_back('{16'd3, 16'd4, 1'b0});
    pulse(4, 3);
    pulse(4, 12);
    pulse(4, 9);
    checks++;
    if ({pulse_count, min_width, max_width, overrun} !== {16'd2, 16'd3, 16'd12, 1'b1}) begin
      errors++;
      $display("FAIL clr_prior: got cnt=%0d min=%0d max=%0d ovr=%b expected cnt=2 min=3 max=12 ovr=1", pulse_count, min_width, max_width, overrun);
    end
    pulse_in = 1'b0;
    cyc(SS + 2);
    clr_stats = 1'b1;
    cyc(1);
    clr_stats = 1'b0;
    checks++;
    if ({pulse_count, min_width, max_width, overrun} !== {16'd1, 16'd9, 16'd9, 1'b0}) begin
      errors++;
      $display("FAIL clr_coincident: got cnt=%0d min=%0d max=%0d ovr=%b expected cnt=1 min=9 max=9 ovr=0", pulse_count, min_width, max_width, overrun);
    end
    checks++;
    if ({meas_valid, meas_width} !== {1'b1, 16'd3}) begin
      errors++;
      $display("FAIL clr_record_kept: got v=%b w=%0d expected v=1 w=3", meas_valid, meas_width);
    end
    meas_ready = 1'b1;
    cyc(1);
    meas_ready = 1'b0;
  endtask

  task automatic test_ena_rise();
    restart();
    meas_ready = 1'b1;
    sb.push_back('{16'd6, 16'd4, 1'b0});
    pulse(4, 6);
    pulse_in = 1'b0;
    cyc(SS + 3);
    checks++;
    if ({meas_valid, meas_width, meas_gap, pulse_count} !== {1'b1, 16'd6, 16'd4, 16'd1}) begin
      errors++;
      $display("FAIL ena_rise: got v=%b w=%0d g=%0d cnt=%0d expected v=1 w=6 g=4 cnt=1", meas_valid, meas_width, meas_gap, pulse_count);
    end
    cyc(1);
  endtask

  task automatic test_abandon();
    restart();
    pulse(4, 3);
    pulse_in = 1'b0;
    cyc(5);
    pulse_in = 1'b1;
    cyc(3);
    ena = 1'b0;
    cyc(2);
    pulse_in = 1'b0;
    cyc(SS + 6);
    checks++;
    if ({meas_valid, meas_width, pulse_count} !== {1'b1, 16'd3, 16'd1}) begin
      errors++;
      $display("FAIL abandon_no_record: got v=%b w=%0d cnt=%0d expected v=1 w=3 cnt=1", meas_valid, meas_width, pulse_count);
    end
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    got_all = {meas_valid, meas_width, meas_gap, meas_sat, pulse_count, min_width, max_width, overrun};
    exp_all = {1'b0, 16'd0, 16'd0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 1'b0};
    checks++;
    if (got_all !== exp_all) begin
      errors++;
      $display("FAIL abandon_reset: got %h expected %h", got_all, exp_all);
    end
  endtask

  task automatic test_saturation();
    restart();
    meas_ready = 1'b1;
    sb.push_back('{16'hFFFF, 16'd4, 1'b1});
    pulse(4, 70000);
    pulse_in = 1'b0;
    cyc(SS + 3);
    checks++;
    if ({meas_valid, meas_width, meas_sat} !== {1'b1, 16'hFFFF, 1'b1}) begin
      errors++;
      $display("FAIL saturation: got v=%b w=%0d s=%b expected v=1 w=65535 s=1", meas_valid, meas_width, meas_sat);
    end
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_clr_coincident();
    test_ena_rise();
    test_abandon();
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
